// File: rtl/cfg_seq_pkg.sv
// Purpose : shared types for the config command sequencer (opcodes, FSM states, command record).
// Latency : n/a (types only).
// Backpres: n/a.
package cfg_seq_pkg;

    localparam int CMD_DATA_W = 8;

    // Bit positions inside the 3-bit downstream cfg bus.
    localparam int CFG_RE   = 0;
    localparam int CFG_WE   = 1;
    localparam int CFG_LOCK = 2;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_SET_RE = 2'b01,
        OP_WRITE  = 2'b10,
        OP_LOCK   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HOLD    = 2'b01,
        ST_RELEASE = 2'b10,
        ST_LOCKED  = 2'b11
    } state_e;

    typedef struct packed {
        op_e                   op;
        logic [CMD_DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/cfg_cmd_fifo.sv
// Purpose : synchronous command buffer of cmd_t, FIFO_DEP entries, show-ahead read (dout = head).
// Latency : a pushed entry is visible on dout the cycle after the push edge.
// Backpres: full when FIFO_DEP entries held; a push while full is taken only if a pop frees the slot.
// Ports   : push/din write side, pop/dout read side, full/empty/level status; clk, rst_n (sync, active-low).
module cfg_cmd_fifo
    import cfg_seq_pkg::*;
#(
    parameter  int FIFO_DEP = 4,
    localparam int AW       = $clog2(FIFO_DEP)
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  cmd_t        din,
    input  logic        pop,
    output cmd_t        dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    cmd_t        mem [FIFO_DEP];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_en;
    logic        rd_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cfg_cmd_seq.sv
// Purpose : turns buffered host commands into the cfg/wd stream of the lockable register stage.
// Latency : command popped at edge t drives cfg at t+1; WRITE completes (done) at t+HOLD_CYC+1.
// Backpres: cmd_ready = rst_n & !fifo_full; host holds cmd_valid until accepted.
// Ports   : cmd_valid/cmd_ready/cmd_op/cmd_data host side; cfg/wd downstream; busy/locked/done/err status.
module cfg_cmd_seq
    import cfg_seq_pkg::*;
#(
    parameter int DATA_W   = CMD_DATA_W,
    parameter int HOLD_CYC = 2,
    parameter int FIFO_DEP = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [2:0]        cfg,
    output logic [DATA_W-1:0] wd,
    output logic              busy,
    output logic              locked,
    output logic              done,
    output logic              err
);

    localparam int            CW       = $clog2(HOLD_CYC + 1);
    localparam int            LW       = $clog2(FIFO_DEP) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e            state;
    state_e            state_nxt;
    cmd_t              head;
    cmd_t              din;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LW-1:0]     level;
    logic [LW-1:0]     level_nxt;
    logic              push;
    logic              pop;
    logic              can_pop;
    logic              re_q;
    logic              re_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [2:0]        cfg_nxt;
    logic [DATA_W-1:0] wd_nxt;
    logic              done_nxt;
    logic              err_nxt;

    assign cmd_ready = rst_n && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign din       = '{op: op_e'(cmd_op), data: cmd_data};

    // RELEASE counts as idle for popping: done is already being issued, and
    // we is low this cycle, so a following WRITE still sees a one-cycle gap.
    assign can_pop   = (state == ST_IDLE) || (state == ST_RELEASE) || (state == ST_LOCKED);
    assign pop       = can_pop && !fifo_empty;
    assign level_nxt = level + LW'(push) - LW'(pop);

    cfg_cmd_fifo #(.FIFO_DEP(FIFO_DEP)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RELEASE: begin
                state_nxt = ST_IDLE;
                if (pop) begin
                    case (head.op)
                        OP_WRITE: state_nxt = ST_HOLD;
                        OP_LOCK:  state_nxt = ST_LOCKED;
                        default:  state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_HOLD:   if (cnt == '0) state_nxt = ST_RELEASE;
            ST_LOCKED: state_nxt = ST_LOCKED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        cfg_nxt  = cfg;
        wd_nxt   = wd;
        re_nxt   = re_q;
        cnt_nxt  = cnt;
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        case (state)
            ST_IDLE, ST_RELEASE: begin
                cfg_nxt[CFG_WE] = 1'b0;
                if (pop) begin
                    case (head.op)
                        OP_SET_RE: begin
                            re_nxt          = head.data[0];
                            cfg_nxt[CFG_RE] = head.data[0];
                            done_nxt        = 1'b1;
                        end
                        OP_WRITE: begin
                            cfg_nxt[CFG_WE] = 1'b1;
                            wd_nxt          = head.data;
                            cnt_nxt         = CNT_LOAD;
                        end
                        OP_LOCK: begin
                            cfg_nxt[CFG_LOCK] = 1'b1;
                            done_nxt          = 1'b1;
                        end
                        default: done_nxt = 1'b1;
                    endcase
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    cfg_nxt[CFG_WE] = 1'b0;
                    done_nxt        = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            // Everything reaching the head after lock is discarded; cfg/wd stay frozen.
            ST_LOCKED: err_nxt = pop;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg    <= '0;
            wd     <= '0;
            re_q   <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
            locked <= 1'b0;
        end else begin
            cfg    <= cfg_nxt;
            wd     <= wd_nxt;
            re_q   <= re_nxt;
            cnt    <= cnt_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
            busy   <= (state_nxt != ST_IDLE) || (level_nxt != '0);
            // One cycle behind cfg[LOCK], matching when downstream captures it.
            locked <= locked || cfg[CFG_LOCK];
        end
    end

endmodule

// File: tb/tb_cfg_cmd_seq.sv
// Purpose : directed self-checking bench for cfg_cmd_seq (default parameters).
// Latency : n/a.
// Backpres: host model holds cmd_valid until cmd_ready.
module tb_cfg_cmd_seq;
    import cfg_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic [2:0] cfg;
    logic [7:0] wd;
    logic       busy, locked, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    cfg_cmd_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cfg       (cfg),
        .wd        (wd),
        .busy      (busy),
        .locked    (locked),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command and holds it until accepted; returns at #1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [7:0] d, output bit ok);
        ok        = 1'b0;
        cmd_op    = op;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        if (cfg !== 3'b000) begin n_bad++; $display("FAIL rst_cfg: got %b expected 000", cfg); end n_cmp++;
        if (wd !== 8'h00) begin n_bad++; $display("FAIL rst_wd: got %h expected 00", wd); end n_cmp++;
        if ({busy, locked, done, err} !== 4'b0000) begin n_bad++; $display("FAIL rst_flags: got %b expected 0000", {busy, locked, done, err}); end n_cmp++;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_low: got %b expected 0", cmd_ready); end n_cmp++;
        rst_n = 1'b1;
        tick();
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b expected 1", cmd_ready); end n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy_after: got %b expected 0", busy); end n_cmp++;
    endtask

    // WRITE 0xA5 from idle with re=0: we high for two cycles, then done.
    task automatic test_write(input string tag);
        bit ok;
        send(OP_WRITE, 8'hA5, ok);
        if (ok !== 1'b1) begin n_bad++; $display("FAIL %s_accept: got %b expected 1", tag, ok); end n_cmp++;
        if (cfg !== 3'b000) begin n_bad++; $display("FAIL %s_cfg_t0: got %b expected 000", tag, cfg); end n_cmp++;
        tick();
        if (cfg !== 3'b010) begin n_bad++; $display("FAIL %s_cfg_t1: got %b expected 010", tag, cfg); end n_cmp++;
        if (wd !== 8'hA5) begin n_bad++; $display("FAIL %s_wd_t1: got %h expected a5", tag, wd); end n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_t1: got %b expected 0", tag, done); end n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy_t1: got %b expected 1", tag, busy); end n_cmp++;
        tick();
        if (cfg !== 3'b010) begin n_bad++; $display("FAIL %s_cfg_t2: got %b expected 010", tag, cfg); end n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_t2: got %b expected 0", tag, done); end n_cmp++;
        tick();
        if (cfg !== 3'b000) begin n_bad++; $display("FAIL %s_cfg_t3: got %b expected 000", tag, cfg); end n_cmp++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL %s_done_t3: got %b expected 1", tag, done); end n_cmp++;
        if (wd !== 8'hA5) begin n_bad++; $display("FAIL %s_wd_t3: got %h expected a5", tag, wd); end n_cmp++;
        tick();
        if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_t4: got %b expected 0", tag, done); end n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_t4: got %b expected 0", tag, busy); end n_cmp++;
    endtask

    task automatic test_set_re();
        bit ok1, ok2;
        send(OP_NOP, 8'hFF, ok1);
        tick();
        if ({cfg, done} !== 4'b0001) begin n_bad++; $display("FAIL nop_cfg_done: got %b expected 0001", {cfg, done}); end n_cmp++;
        tick();
        send(OP_SET_RE, 8'h01, ok1);
        send(OP_WRITE, 8'h3C, ok2);
        if ({ok1, ok2} !== 2'b11) begin n_bad++; $display("FAIL setre_accept: got %b expected 11", {ok1, ok2}); end n_cmp++;
        if ({cfg, done} !== 4'b0011) begin n_bad++; $display("FAIL setre_cfg_done: got %b expected 0011", {cfg, done}); end n_cmp++;
        tick();
        if ({cfg, done} !== 4'b0110) begin n_bad++; $display("FAIL setre_wr_t1: got %b expected 0110", {cfg, done}); end n_cmp++;
        if (wd !== 8'h3C) begin n_bad++; $display("FAIL setre_wd: got %h expected 3c", wd); end n_cmp++;
        tick();
        if ({cfg, done} !== 4'b0110) begin n_bad++; $display("FAIL setre_wr_t2: got %b expected 0110", {cfg, done}); end n_cmp++;
        tick();
        if ({cfg, done} !== 4'b0011) begin n_bad++; $display("FAIL setre_wr_t3: got %b expected 0011", {cfg, done}); end n_cmp++;
        tick();
        if (done !== 1'b0) begin n_bad++; $display("FAIL setre_done_t4: got %b expected 0", done); end n_cmp++;
    endtask

    // Eight WRITEs streamed with valid held; the FIFO fills while the FSM sits in HOLD.
    task automatic test_back_to_back();
        int sent = 0, got = 0, dones = 0, low_at = -1, run = 0;
        bit rdy_s, prev_we = 1'b0;
        cmd_op = OP_WRITE;
        for (int cyc = 0; cyc < 300 && dones < 8; cyc++) begin
            cmd_valid = (sent < 8);
            cmd_data  = 8'h10 + 8'(sent);
            rdy_s     = cmd_ready;
            if (cmd_valid && !rdy_s && low_at < 0) low_at = sent;
            tick();
            if (cmd_valid && rdy_s) sent++;
            if (cfg[CFG_WE] && !prev_we) begin
                if (wd !== 8'h10 + 8'(got)) begin n_bad++; $display("FAIL b2b_order_%0d: got %h expected %h", got, wd, 8'h10 + 8'(got)); end n_cmp++;
                got++;
            end
            if (cfg[CFG_WE]) run++;
            if (!cfg[CFG_WE] && prev_we) begin
                if (run !== 2) begin n_bad++; $display("FAIL b2b_we_len: got %0d expected 2", run); end n_cmp++;
                run = 0;
            end
            prev_we = cfg[CFG_WE];
            if (done) dones++;
        end
        cmd_valid = 1'b0;
        if (low_at !== 6) begin n_bad++; $display("FAIL b2b_full_after: got %0d expected 6", low_at); end n_cmp++;
        if (got !== 8) begin n_bad++; $display("FAIL b2b_writes: got %0d expected 8", got); end n_cmp++;
        if (dones !== 8) begin n_bad++; $display("FAIL b2b_dones: got %0d expected 8", dones); end n_cmp++;
        tick(); tick();
        if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end n_cmp++;
    endtask

    task automatic test_reset_mid_hold();
        bit ok1, ok2;
        int dones = 0;
        send(OP_WRITE, 8'h11, ok1);
        send(OP_NOP, 8'h00, ok2);
        if ({cfg[CFG_WE], wd} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL mid_in_hold: got %b/%h expected 1/11", cfg[CFG_WE], wd); end n_cmp++;
        rst_n = 1'b0;
        tick();
        if ({cfg, wd} !== 11'h000) begin n_bad++; $display("FAIL mid_rst_cfg_wd: got %b/%h expected 000/00", cfg, wd); end n_cmp++;
        if ({busy, done, cmd_ready} !== 3'b000) begin n_bad++; $display("FAIL mid_rst_flags: got %b expected 000", {busy, done, cmd_ready}); end n_cmp++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) dones++;
        end
        if (dones !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d expected 0", dones); end n_cmp++;
        if ({busy, cfg} !== 4'b0000) begin n_bad++; $display("FAIL mid_empty_idle: got %b expected 0000", {busy, cfg}); end n_cmp++;
        test_write("post");
    endtask

    task automatic test_lock();
        bit ok1, ok2, ok3;
        send(OP_LOCK, 8'h00, ok1);
        send(OP_WRITE, 8'hFF, ok2);
        if ({cfg, done, locked, err} !== 6'b100100) begin n_bad++; $display("FAIL lock_t1: got %b expected 100100", {cfg, done, locked, err}); end n_cmp++;
        send(OP_SET_RE, 8'h00, ok3);
        if ({ok1, ok2, ok3} !== 3'b111) begin n_bad++; $display("FAIL lock_accept: got %b expected 111", {ok1, ok2, ok3}); end n_cmp++;
        if ({cfg, done, locked, err} !== 6'b100011) begin n_bad++; $display("FAIL lock_t2: got %b expected 100011", {cfg, done, locked, err}); end n_cmp++;
        tick();
        if ({cfg, done, locked, err} !== 6'b100011) begin n_bad++; $display("FAIL lock_t3: got %b expected 100011", {cfg, done, locked, err}); end n_cmp++;
        tick();
        if ({cfg, done, locked, err} !== 6'b100010) begin n_bad++; $display("FAIL lock_t4: got %b expected 100010", {cfg, done, locked, err}); end n_cmp++;
        if (wd !== 8'hA5) begin n_bad++; $display("FAIL lock_wd: got %h expected a5", wd); end n_cmp++;
        send(OP_LOCK, 8'h00, ok1);
        tick();
        if ({cfg, done, err} !== 5'b10001) begin n_bad++; $display("FAIL lock_second: got %b expected 10001", {cfg, done, err}); end n_cmp++;
        tick();
        if ({err, cmd_ready, locked} !== 3'b011) begin n_bad++; $display("FAIL lock_settle: got %b expected 011", {err, cmd_ready, locked}); end n_cmp++;
    endtask

    initial begin
        #1;
        test_reset();
        test_write("wr");
        test_set_re();
        test_back_to_back();
        test_reset_mid_hold();
        test_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
